// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and FSM encoding for the segment display arbiter
package seg_pkg;

  localparam int DIGIT_W = 5;
  localparam int DIGIT_N = 4;
  localparam int DISP_W  = DIGIT_W * DIGIT_N;
  localparam int CNT_W   = 26;

  typedef logic [1:0]        state_t;
  typedef logic [DISP_W-1:0] disp_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Index of the set bit of a one-hot 3-bit vector (0 when none is set).
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational 3-way round-robin winner selection
module rr_pick3
  import seg_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_owner,
  output logic [2:0] winner,
  output logic       valid
);

  // Search starts just after the previous owner and wraps 2->0.
  always_comb begin
    winner = 3'b000;
    case (last_owner)
      2'd0: begin
        if (req[1])      winner = 3'b010;
        else if (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
      end
      2'd1: begin
        if (req[2])      winner = 3'b100;
        else if (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
      end
      default: begin
        if (req[0])      winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
      end
    endcase
    valid = |req;
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - time-sliced arbiter sharing one 4-digit display among 3 requesters
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int          DWELL        = 50000000,
  parameter int          GAP          = 5000000,
  parameter logic [19:0] IDLE_PATTERN = 20'h00000
) (
  input  logic        mclk,
  input  logic        rst_N,
  input  logic [2:0]  req,
  input  logic [59:0] req_digits,
  output logic [2:0]  grant,
  output logic [19:0] digits_out,
  output logic        busy
);

  localparam logic [CNT_W-1:0] DWELL_MAX  = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  state_t           state;
  logic [1:0]       last_owner;
  logic [CNT_W-1:0] dwell_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [2:0]       pick_win;
  logic             pick_valid;
  disp_t            owner_digits;
  logic             owner_req;
  logic             others_req;

  rr_pick3 u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick_win),
    .valid      (pick_valid)
  );

  // During SHOW last_owner is the current owner, so it selects the live digit slice.
  always_comb begin
    owner_digits = req_digits[19:0];
    case (last_owner)
      2'd1:    owner_digits = req_digits[39:20];
      2'd2:    owner_digits = req_digits[59:40];
      default: owner_digits = req_digits[19:0];
    endcase
    owner_req  = |(req & grant);
    others_req = |(req & ~grant);
  end

  assign busy = (state != ST_IDLE);

  // Arbitration FSM: IDLE picks a winner, SHOW holds it for the dwell, GAP blanks between owners.
  always_ff @(posedge mclk or negedge rst_N) begin
    if (!rst_N) begin
      state      <= ST_IDLE;
      grant      <= 3'b000;
      digits_out <= IDLE_PATTERN;
      dwell_cnt  <= '0;
      gap_cnt    <= '0;
      last_owner <= 2'd2;
    end else begin
      case (state)
        ST_IDLE: begin
          grant      <= 3'b000;
          digits_out <= IDLE_PATTERN;
          if (pick_valid) begin
            grant      <= pick_win;
            last_owner <= onehot_to_idx(pick_win);
            dwell_cnt  <= '0;
            state      <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (!owner_req || (dwell_cnt >= DWELL_LAST && others_req)) begin
            grant      <= 3'b000;
            digits_out <= IDLE_PATTERN;
            gap_cnt    <= '0;
            state      <= ST_GAP;
          end else begin
            digits_out <= owner_digits;
            if (dwell_cnt < DWELL_MAX) dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          digits_out <= IDLE_PATTERN;
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          grant      <= 3'b000;
          digits_out <= IDLE_PATTERN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - scoreboard bench for seg_display_arbiter
module tb_seg_display_arbiter;

  localparam int          DWELL = 8;
  localparam int          GAP   = 3;
  localparam logic [19:0] IDLE  = 20'h5A5A5;
  localparam logic [19:0] D0    = 20'hA1B2C;
  localparam logic [19:0] D1    = 20'h3D4E5;
  localparam logic [19:0] D2    = 20'h6F708;
  localparam logic [19:0] D2B   = 20'h0C3E1;

  logic        mclk = 1'b0;
  logic        rst_N = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [59:0] req_digits = {D2, D1, D0};
  logic [2:0]  grant;
  logic [19:0] digits_out;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [23:0] prev;
  int r;

  typedef struct {
    int          cyc;
    logic [2:0]  g;
    logic [19:0] d;
    logic        b;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  seg_display_arbiter #(
    .DWELL        (DWELL),
    .GAP          (GAP),
    .IDLE_PATTERN (IDLE)
  ) dut (
    .mclk       (mclk),
    .rst_N      (rst_N),
    .req        (req),
    .req_digits (req_digits),
    .grant      (grant),
    .digits_out (digits_out),
    .busy       (busy)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int c, input logic [2:0] g, input logic [19:0] d, input logic b);
    exp_t e;
    e.cyc = c;
    e.g   = g;
    e.d   = d;
    e.b   = b;
    sbq.push_back(e);
  endtask

  task automatic start(input logic [2:0] rq, output int r0);
    mon_en = 1'b0;
    rst_N  = 1'b0;
    req    = rq;
    step(2);
    chk("reset grant", grant, 3'b000);
    chk("reset digits", digits_out, IDLE);
    chk("reset busy", busy, 1'b0);
    rst_N  = 1'b1;
    r0     = cyc;
    prev   = {grant, digits_out, busy};
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    step(3);
    chk({name, " queue empty"}, sbq.size(), 0);
  endtask

  // Monitor: every output change is popped against the next expected event.
  initial begin
    forever begin
      @(negedge mclk);
      if (mon_en && ({grant, digits_out, busy} !== prev)) begin
        prev = {grant, digits_out, busy};
        checks++;
        if ($onehot0(grant) !== 1'b1) begin
          failures++;
          $display("FAIL grant_onehot at cycle %0d: got %b", cyc, grant);
        end
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change at cycle %0d: grant=%b digits=%h busy=%b", cyc, grant, digits_out, busy);
        end else begin
          mon_e = sbq.pop_front();
          if (mon_e.cyc != cyc || mon_e.g !== grant || mon_e.d !== digits_out || mon_e.b !== busy) begin
            failures++;
            $display("FAIL event: got cycle=%0d grant=%b digits=%h busy=%b expected cycle=%0d grant=%b digits=%h busy=%b",
                     cyc, grant, digits_out, busy, mon_e.cyc, mon_e.g, mon_e.d, mon_e.b);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // All three requesting: rotation 0,1,2,0 with dwell 8 and gap 3.
    start(3'b111, r);
    expect_ev(r + 1,  3'b001, IDLE, 1'b1);
    expect_ev(r + 2,  3'b001, D0,   1'b1);
    expect_ev(r + 9,  3'b000, IDLE, 1'b1);
    expect_ev(r + 12, 3'b000, IDLE, 1'b0);
    expect_ev(r + 13, 3'b010, IDLE, 1'b1);
    expect_ev(r + 14, 3'b010, D1,   1'b1);
    expect_ev(r + 21, 3'b000, IDLE, 1'b1);
    expect_ev(r + 24, 3'b000, IDLE, 1'b0);
    expect_ev(r + 25, 3'b100, IDLE, 1'b1);
    expect_ev(r + 26, 3'b100, D2,   1'b1);
    expect_ev(r + 33, 3'b000, IDLE, 1'b1);
    expect_ev(r + 36, 3'b000, IDLE, 1'b0);
    expect_ev(r + 37, 3'b001, IDLE, 1'b1);
    expect_ev(r + 38, 3'b001, D0,   1'b1);
    drain("rr_all");

    // Owner 0, requester 1 joins at SHOW cycle 2, then everyone releases.
    start(3'b001, r);
    expect_ev(r + 1,  3'b001, IDLE, 1'b1);
    expect_ev(r + 2,  3'b001, D0,   1'b1);
    expect_ev(r + 9,  3'b000, IDLE, 1'b1);
    expect_ev(r + 12, 3'b000, IDLE, 1'b0);
    expect_ev(r + 13, 3'b010, IDLE, 1'b1);
    expect_ev(r + 14, 3'b010, D1,   1'b1);
    expect_ev(r + 16, 3'b000, IDLE, 1'b1);
    expect_ev(r + 19, 3'b000, IDLE, 1'b0);
    step(2);
    req = 3'b011;
    step(13);
    req = 3'b000;
    drain("dwell_handover");

    // Lone requester 2 keeps the display past the dwell; live digit tracking.
    start(3'b100, r);
    expect_ev(r + 1,  3'b100, IDLE, 1'b1);
    expect_ev(r + 2,  3'b100, D2,   1'b1);
    expect_ev(r + 21, 3'b100, D2B,  1'b1);
    expect_ev(r + 51, 3'b000, IDLE, 1'b1);
    expect_ev(r + 54, 3'b000, IDLE, 1'b0);
    step(20);
    req_digits[59:40] = D2B;
    step(30);
    chk("hold grant", grant, 3'b100);
    req = 3'b000;
    drain("single_hold");
    req_digits[59:40] = D2;

    // Owner 1 drops at SHOW cycle 1: immediate gap of 3 busy cycles.
    start(3'b010, r);
    expect_ev(r + 1, 3'b010, IDLE, 1'b1);
    expect_ev(r + 2, 3'b000, IDLE, 1'b1);
    expect_ev(r + 5, 3'b000, IDLE, 1'b0);
    step(1);
    req = 3'b000;
    drain("early_drop");

    // Asynchronous reset mid-SHOW.
    start(3'b001, r);
    expect_ev(r + 1, 3'b001, IDLE, 1'b1);
    expect_ev(r + 2, 3'b001, D0,   1'b1);
    step(3);
    chk("mid_show queue", sbq.size(), 0);
    mon_en = 1'b0;
    rst_N  = 1'b0;
    #1;
    chk("async show grant", grant, 3'b000);
    chk("async show digits", digits_out, IDLE);
    chk("async show busy", busy, 1'b0);

    // Asynchronous reset mid-GAP.
    start(3'b001, r);
    expect_ev(r + 1, 3'b001, IDLE, 1'b1);
    expect_ev(r + 2, 3'b000, IDLE, 1'b1);
    step(1);
    req = 3'b000;
    step(2);
    chk("mid_gap busy", busy, 1'b1);
    chk("mid_gap queue", sbq.size(), 0);
    mon_en = 1'b0;
    rst_N  = 1'b0;
    #1;
    chk("async gap grant", grant, 3'b000);
    chk("async gap digits", digits_out, IDLE);
    chk("async gap busy", busy, 1'b0);
    step(1);
    rst_N = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
